// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one 8x8 sequential
// multiplier (start/done interface) among NUM_REQ requesters, with one
// multiplication in flight at a time.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort a multiplication
// that has not signalled done after TIMEOUT cycles in WAIT. The abort is
// returned as rsp_product=0 with rsp_err=1. Without the macro WAIT waits
// indefinitely and rsp_err is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | round-robin scan of req_valid, accept winner, latch operands
// START | one-cycle mult_start pulse, clear wait counter
// WAIT  | wait for mult_done (or timeout when enabled)
// RESP  | hold rsp_valid/product/err until granted requester's rsp_ready
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [15:0]          rsp_product,
  output logic                 rsp_err,
  output logic                 mult_start,
  output logic [7:0]           mult_a,
  output logic [7:0]           mult_b,
  input  logic                 mult_done,
  input  logic [15:0]          mult_product,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    WAIT  = 3'b010,
    RESP  = 3'b011
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..255");
  end

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr;
  logic [2:0]  sel;
  logic        sel_found;
  logic        accept;
  logic        rsp_hs;
  logic        done_hit;
  logic        timeout_hit;
  logic [NUM_REQ-1:0] grant_onehot;

  // Padded copies so a 3-bit requester index always selects in range.
  logic [7:0]  valid_pad;
  logic [7:0]  ready_pad;
  logic [63:0] a_pad;
  logic [63:0] b_pad;

  assign valid_pad = 8'(req_valid);
  assign ready_pad = 8'(rsp_ready);
  assign a_pad     = 64'(req_a);
  assign b_pad     = 64'(req_b);

  // Round-robin scan: first set req_valid bit at or after rr_ptr, wrapping.
  always_comb begin
    logic [3:0] idx;
    sel       = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!sel_found && valid_pad[idx[2:0]]) begin
        sel_found = 1'b1;
        sel       = idx[2:0];
      end
    end
  end

  assign accept   = (state == IDLE) && sel_found;
  assign rsp_hs   = (state == RESP) && ready_pad[grant_id];
  assign done_hit = (state == WAIT) && mult_done;

  // One-hot accept towards the winner, only while scanning in IDLE.
  always_comb begin
    req_ready = '0;
    if (accept && !reset_a) begin
      for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (sel == 3'(i));
    end
  end

  // One-hot form of grant_id for the response valid vector.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_onehot[i] = (grant_id == 3'(i));
  end

`ifdef MULT_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counts WAIT cycles; TIMEOUT-1 means this is the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a)               wait_cnt <= '0;
    else if (state == START)   wait_cnt <= '0;
    else if (state == WAIT)    wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == 8'(TIMEOUT - 1));

  // Error flag: done always wins over a coincident timeout.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a)          rsp_err <= 1'b0;
    else if (done_hit)    rsp_err <= 1'b0;
    else if (timeout_hit) rsp_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and start pulse decode.
  always_comb begin
    state_nxt  = state;
    mult_start = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START: begin
        mult_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:    if (mult_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, result capture, response valid and round-robin pointer.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      mult_a      <= '0;
      mult_b      <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      rsp_product <= '0;
      rsp_valid   <= '0;
    end else begin
      if (accept) begin
        mult_a   <= a_pad[{sel, 3'b000} +: 8];
        mult_b   <= b_pad[{sel, 3'b000} +: 8];
        grant_id <= sel;
      end
      if (done_hit) begin
        rsp_product <= mult_product;
        rsp_valid   <= grant_onehot;
      end else if (timeout_hit) begin
        rsp_product <= '0;
        rsp_valid   <= grant_onehot;
      end
      if (rsp_hs) begin
        rsp_valid <= '0;
        rr_ptr    <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_out = state;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (round-robin pointer, expected
// products from a*b, last delivered product). The bench also plays the
// multiplier, answering with the product of the operands it expects.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam logic [2:0] S_IDLE = 3'b000, S_START = 3'b001, S_WAIT = 3'b010, S_RESP = 3'b011;

  logic           clk = 1'b0;
  logic           reset_a;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [15:0]    rsp_product;
  logic           rsp_err;
  logic           mult_start;
  logic [7:0]     mult_a, mult_b;
  logic           mult_done;
  logic [15:0]    mult_product;
  logic           busy;
  logic [2:0]     grant_id;
  logic [2:0]     state_out;

  int vectors = 0;
  int miscompares = 0;
  int rr_model = 0;
  logic [15:0] last_product = 16'h0;

  mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_a(reset_a),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_product(mult_product),
    .busy(busy), .grant_id(grant_id), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first requester at or after rr, wrapping.
  function automatic int pick(input logic [N-1:0] mask, input int rr);
    for (int k = 0; k < N; k++) begin
      if (mask[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  // One full transaction. done_cyc: WAIT cycle (1-based) on which mult_done
  // is pulsed; 0 means never (timeout expected). bp: cycles of response
  // backpressure, with a stray mult_done pulse in the first of them.
  task automatic run_txn(input logic [N-1:0] mask, input logic [8*N-1:0] av,
                         input logic [8*N-1:0] bv, input int done_cyc, input int bp,
                         input logic hold_valid, output int win, output logic [15:0] got);
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    logic        eerr;
    logic [N-1:0] oh;
    int wc;
    req_a = av; req_b = bv; req_valid = mask;
    #1;
    win = pick(mask, rr_model);
    oh  = N'(1) << win;
    ea  = av[8*win +: 8];
    eb  = bv[8*win +: 8];
    ep  = 16'(ea) * 16'(eb);
    chk("req_ready_onehot", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 0);
    tick();
    if (!hold_valid) req_valid = '0;
    chk("mult_start_pulse", 32'(mult_start), 1);
    chk("state_start", 32'(state_out), 32'(S_START));
    chk("grant_id", 32'(grant_id), 32'(win));
    chk("mult_a", 32'(mult_a), 32'(ea));
    chk("mult_b", 32'(mult_b), 32'(eb));
    chk("req_ready_busy", 32'(req_ready), 0);
    tick();
    chk("mult_start_once", 32'(mult_start), 0);
    chk("state_wait", 32'(state_out), 32'(S_WAIT));
    if (done_cyc > 0) begin
      for (int c = 1; c < done_cyc; c++) tick();
      chk("still_wait", 32'(state_out), 32'(S_WAIT));
      chk("no_rsp_in_wait", 32'(rsp_valid), 0);
      mult_done = 1'b1; mult_product = ep;
      tick();
      mult_done = 1'b0; mult_product = 16'($urandom);
      eerr = 1'b0;
    end else begin
      wc = 0;
      while (state_out === S_WAIT && wc < 60) begin
        wc++;
        tick();
      end
      chk("timeout_wait_cycles", 32'(wc), 32'(TO));
      ep = 16'h0; eerr = 1'b1;
    end
    chk("state_resp", 32'(state_out), 32'(S_RESP));
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_product", 32'(rsp_product), 32'(ep));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    got = rsp_product;
    for (int c = 0; c < bp; c++) begin
      rsp_ready = N'($urandom) & ~oh;
      if (c == 0) begin mult_done = 1'b1; mult_product = ~ep; end
      tick();
      mult_done = 1'b0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("bp_rsp_product", 32'(rsp_product), 32'(ep));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = oh | (N'($urandom) & ~oh);
    tick();
    rsp_ready = '0;
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
    chk("state_idle", 32'(state_out), 32'(S_IDLE));
    rr_model = (win + 1) % N;
    last_product = ep;
  endtask

  initial begin
    int win;
    int rr_order [6] = '{0, 1, 3, 0, 1, 3};
    logic [15:0] got;
    logic [8*N-1:0] av, bv;

    reset_a = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    mult_done = 1'b0; mult_product = '0;
    tick(); tick();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mult_start", 32'(mult_start), 0);
    chk("rst_product", 32'(rsp_product), 0);
    chk("rst_operands", 32'({mult_a, mult_b}), 0);
    chk("rst_grant", 32'(grant_id), 0);
    reset_a = 1'b0;
    tick();

    // Round robin with requesters 0, 1, 3 held continuously.
    for (int t = 0; t < 6; t++) begin
      av = 32'($urandom); bv = 32'($urandom);
      run_txn(4'b1011, av, bv, 2, 0, 1'b1, win, got);
      chk("rr_order", 32'(win), 32'(rr_order[t]));
    end

    // Single request 0xFF * 0xFF, done on the 4th WAIT cycle.
    run_txn(4'b0001, 32'h000000FF, 32'h000000FF, 4, 0, 1'b0, win, got);
    chk("ff_times_ff", 32'(got), 32'h0000FE01);

    // Backpressure on requester 2 (3 * 4) for 5 cycles.
    run_txn(4'b0100, 32'h00030000, 32'h00040000, 3, 5, 1'b0, win, got);
    chk("bp_product", 32'(got), 32'h0000000C);

    // Stray done in IDLE must not start anything or touch the product.
    req_valid = '0;
    mult_done = 1'b1; mult_product = 16'hDEAD;
    tick();
    mult_done = 1'b0;
    chk("stray_idle_busy", 32'(busy), 0);
    chk("stray_idle_product", 32'(rsp_product), 32'(last_product));

    // Request raised and dropped inside one cycle is never latched.
    req_valid = 4'b0010;
    #1;
    chk("drop_ready", 32'(req_ready), 32'h2);
    #1;
    req_valid = '0;
    tick();
    chk("drop_not_taken", 32'(busy), 0);

    // Asynchronous reset in the middle of WAIT (rr pointer is 3 here).
    req_a = 32'h11223344; req_b = 32'h55667788; req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    chk("pre_reset_wait", 32'(state_out), 32'(S_WAIT));
    #2 reset_a = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_operands", 32'({mult_a, mult_b}), 0);
    chk("async_rst_product", 32'(rsp_product), 0);
    chk("async_rst_grant", 32'(grant_id), 0);
    tick();
    reset_a = 1'b0;
    rr_model = 0; last_product = 16'h0;
    tick(); tick();
    mult_done = 1'b1; mult_product = 16'h1234;
    tick();
    mult_done = 1'b0;
    chk("late_done_ignored", 32'(busy), 0);
    chk("late_done_product", 32'(rsp_product), 0);
    av = 32'($urandom); bv = 32'($urandom);
    run_txn(4'b1111, av, bv, 1, 0, 1'b0, win, got);
    chk("post_reset_grant0", 32'(win), 0);

`ifdef MULT_ARB_TIMEOUT_EN
    av = 32'($urandom); bv = 32'($urandom);
    run_txn(4'b0010, av, bv, 0, 2, 1'b0, win, got);
    av = 32'($urandom); bv = 32'($urandom);
    run_txn(4'b0100, av, bv, TO, 0, 1'b0, win, got);
`else
    // Without the timeout, a long WAIT still ends in a normal response.
    av = 32'($urandom); bv = 32'($urandom);
    run_txn(4'b0010, av, bv, 30, 1, 1'b0, win, got);
`endif

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      av = 32'($urandom); bv = 32'($urandom);
      run_txn(N'($urandom_range(1, (1 << N) - 1)), av, bv,
              $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom), win, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one 8x8 sequential multiplier (start/done interface, nominal 4-pass latency) among NUM_REQ requesters.
- Round-robin arbitration, operand capture, one-cycle start pulse to the multiplier, wait for done, product returned to the granted requester over a valid/ready handshake.
- Sits between the requester fabric and the multiplier top level; one multiplication in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT, 15, max cycles in WAIT before abort; legal range 1..255; used only with MULT_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset_a  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request.
- req_a  input  8*NUM_REQ  multiplicand, requester i at bits [8i+7:8i].
- req_b  input  8*NUM_REQ  multiplier, same packing.
- req_ready  output  NUM_REQ  one-hot accept, combinational.
- rsp_valid  output  NUM_REQ  one-hot response valid, registered.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_product  output  16  product for the requester whose rsp_valid is high.
- rsp_err  output  1  response is a timeout abort.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_a, mult_b  output  8 each  operands, held stable from START until leaving WAIT.
- mult_done  input  1  multiplier completion strobe.
- mult_product  input  16  multiplier result, valid when mult_done=1.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  3  index of the current or last granted requester.
- state_out  output  3  encoded state, for debug.

Behaviour:
- States and encodings: IDLE=000, START=001, WAIT=010, RESP=011.
- Reset (asynchronous):
  - state=IDLE; rr_ptr=0; grant_id=0.
  - All outputs 0, including mult_a, mult_b, rsp_product, rsp_err, mult_start.
  - Any in-flight operation is discarded. A later stray mult_done is ignored.
- Arbitration:
  - In IDLE, scan req_valid starting at rr_ptr, ascending with wrap modulo NUM_REQ.
  - The first set bit i wins. req_ready[i]=1 combinationally, in IDLE only.
  - No request: all req_ready=0, stay in IDLE.
- Accept (IDLE, req_valid[i] & req_ready[i]):
  - Latch req_a[i] and req_b[i] into mult_a and mult_b.
  - grant_id<=i; next state START.
- START: mult_start=1 for exactly this one cycle; clear the wait counter; next state WAIT.
- WAIT:
  - On mult_done=1: rsp_product<=mult_product; rsp_err<=0; next state RESP.
  - mult_done in any state other than WAIT is ignored.
- RESP:
  - rsp_valid[grant_id]=1; all other bits 0.
  - rsp_product and rsp_err are held until rsp_ready[grant_id]=1.
  - On that handshake: rr_ptr<=(grant_id+1) mod NUM_REQ; next state IDLE; rsp_valid deasserts the next cycle.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency:
  - Accept to mult_start: 1 cycle.
  - mult_done to rsp_valid: 1 cycle.
  - Minimum back-to-back: a new accept is possible in the cycle after the RESP handshake.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- Requester protocol: req_valid may drop without acceptance; no request is latched in that case.
- Widths: rr_ptr and grant_id are 3 bits, and wrap computations stay within NUM_REQ.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle in WAIT.
  - If it reaches TIMEOUT with no mult_done: rsp_product<=0, rsp_err<=1, next state RESP.
  - If mult_done arrives in the same cycle the counter reaches TIMEOUT, mult_done wins (normal result, rsp_err=0).
- Undefined:
  - No counter; WAIT waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Single request: req 0 with a=0xFF, b=0xFF; done after 4 cycles -> mult_start 1 cycle after accept; rsp_valid[0] with rsp_product=0xFE01, rsp_err=0.
- Round robin: reqs 0, 1, 3 held continuously -> grant order 0,1,3,0,1,3 across 6 transactions; req_ready always one-hot.
- Backpressure: rsp_ready[2] held low for 5 cycles -> rsp_valid[2] and rsp_product=0x0C (a=3, b=4) stable; no new req_ready until the handshake.
- Async reset: reset_a pulsed mid-WAIT -> immediately IDLE, all outputs 0; mult_done 2 cycles later ignored; next request granted from requester 0.
- Timeout (MULT_ARB_TIMEOUT_EN, TIMEOUT=15): mult_done never asserted -> rsp_valid after 15 WAIT cycles, rsp_product=0, rsp_err=1. Repeat with mult_done on the 15th cycle -> normal result, rsp_err=0.
- Stray done: mult_done pulsed in IDLE and RESP -> no state change, rsp_product unchanged.
